// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: WIDTH-bit word in over valid/ready, MSB-first serial out.
// Optional even-parity bit after the data bits when PISO_TX_PARITY_EN is defined.
module piso_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             last
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  localparam bit HAS_PAR = 1'b1;
  logic par;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
  localparam bit HAS_PAR = 1'b0;
`endif

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             xfer;

  // last is registered and marks the final bit on the wire, so accepting the
  // next word during that bit gives gap-free back-to-back frames.
  assign din_ready = !rst && ((state == IDLE) || last);
  assign xfer      = din_valid && din_ready;

  // cnt holds the number of data bits still to shift after the one on sdo.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      sdo       <= 1'b0;
      sdo_valid <= 1'b0;
      last      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else if (xfer) begin
      state     <= SHIFT;
      sdo       <= din[WIDTH-1];
      sdo_valid <= 1'b1;
      sreg      <= {din[WIDTH-2:0], 1'b0};
      cnt       <= CW'(WIDTH - 1);
      last      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par       <= ^din;
`endif
    end else if ((state == SHIFT) && (cnt != '0)) begin
      sdo       <= sreg[WIDTH-1];
      sdo_valid <= 1'b1;
      sreg      <= {sreg[WIDTH-2:0], 1'b0};
      cnt       <= cnt - CW'(1);
      last      <= !HAS_PAR && (cnt == CW'(1));
`ifdef PISO_TX_PARITY_EN
    end else if (state == SHIFT) begin
      state     <= PARITY;
      sdo       <= par;
      sdo_valid <= 1'b1;
      last      <= 1'b1;
`endif
    end else begin
      state     <= IDLE;
      sdo       <= 1'b0;
      sdo_valid <= 1'b0;
      last      <= 1'b0;
    end
  end

endmodule
